// File: rtl/filtro_botoes.sv
// Button conditioning for the game datapath: two-flop synchroniser, debounce FSM and
// multi-button rejection, producing a registered all-zero or one-hot press vector.
module filtro_botoes #(
    parameter int unsigned DEBOUNCE_CYCLES = 5,
    parameter int unsigned CW              = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] botoes_raw,
    input  logic       enable,
    output logic [8:0] botoes,
    output logic       erro_multiplo,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        StOcioso     = 3'd0,
        StEstabiliza = 3'd1,
        StAceito     = 3'd2,
        StRejeitado  = 3'd3,
        StSoltando   = 3'd4
    } estado_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [8:0]    r_sync1;
    logic [8:0]    r_sync2;
    estado_t       r_estado;
    estado_t       w_estado_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;
    logic [8:0]    r_cand;
    logic [8:0]    w_cand_d;
    logic [8:0]    r_botoes;
    logic [8:0]    w_botoes_d;
    logic          r_erro;
    logic          w_erro_d;
    logic          w_onehot;
    logic          w_sync_zero;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= botoes_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync_zero = (r_sync2 == '0);
    assign w_onehot    = (r_cand != '0) && ((r_cand & (r_cand - 9'd1)) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= StOcioso;
            r_cnt    <= '0;
            r_cand   <= '0;
            r_botoes <= '0;
            r_erro   <= 1'b0;
        end else begin
            r_estado <= w_estado_d;
            r_cnt    <= w_cnt_d;
            r_cand   <= w_cand_d;
            r_botoes <= w_botoes_d;
            r_erro   <= w_erro_d;
        end
    end

    always_comb begin
        w_estado_d = r_estado;
        w_cnt_d    = r_cnt;
        w_cand_d   = r_cand;
        w_botoes_d = r_botoes;
        w_erro_d   = 1'b0;

        case (r_estado)
            StOcioso: begin
                w_botoes_d = '0;
                // enable only gates starting a press; an ongoing press always completes
                if (!w_sync_zero && enable) begin
                    w_cand_d   = r_sync2;
                    w_cnt_d    = '0;
                    w_estado_d = StEstabiliza;
                end
            end

            StEstabiliza: begin
                if (w_sync_zero) begin
                    w_estado_d = StOcioso;
                end else if (r_sync2 != r_cand) begin
                    w_cand_d = r_sync2;
                    w_cnt_d  = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_cnt_d = '0;
                    if (w_onehot) begin
                        w_botoes_d = r_cand;
                        w_estado_d = StAceito;
                    end else begin
                        w_erro_d   = 1'b1;
                        w_estado_d = StRejeitado;
                    end
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end

            StAceito: begin
                if (w_sync_zero) begin
                    w_cnt_d    = '0;
                    w_estado_d = StSoltando;
                end
            end

            StSoltando, StRejeitado: begin
                // any activity restarts the release count
                if (!w_sync_zero) begin
                    w_cnt_d = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_botoes_d = '0;
                    w_cnt_d    = '0;
                    w_estado_d = StOcioso;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end

            default: begin
                w_botoes_d = '0;
                w_cnt_d    = '0;
                w_estado_d = StOcioso;
            end
        endcase
    end

    assign botoes        = r_botoes;
    assign erro_multiplo = r_erro;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_filtro_botoes.sv
// Directed bench for filtro_botoes (DEBOUNCE_CYCLES = 5): vector table for the main
// press/reject/enable flows plus hand sequences for bounce and mid-press reset.
module tb_filtro_botoes;

    logic       clock;
    logic       reset;
    logic [8:0] botoes_raw;
    logic       enable;
    logic [8:0] botoes;
    logic       erro_multiplo;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    int viol   = 0;
    int pulsos = 0;

    filtro_botoes #(
        .DEBOUNCE_CYCLES(5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes_raw   (botoes_raw),
        .enable       (enable),
        .botoes       (botoes),
        .erro_multiplo(erro_multiplo),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] raw;
        logic       en;
        int         ciclos;
        logic [8:0] exp_bot;
        logic       exp_erro;
        logic [2:0] exp_est;
    } vetor_t;

    vetor_t tab[17];

    // Output invariant watcher: only 0 <-> single one-hot value changes are legal.
    logic [8:0] prev_bot = '0;
    always @(negedge clock) begin
        if (botoes != '0 && ((botoes & (botoes - 9'd1)) != '0)) viol++;
        if (prev_bot != '0 && botoes != '0 && botoes != prev_bot) viol++;
        if (prev_bot == '0 && botoes != '0) rises++;
        if (erro_multiplo) pulsos++;
        prev_bot = botoes;
    end

    task automatic ciclo(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checa(input string nome, input logic [31:0] atual,
                         input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic checa_saidas(input string nome, input logic [8:0] bot, input logic erro,
                                input logic [2:0] est);
        checa({nome, " botoes"}, 32'(botoes), 32'(bot));
        checa({nome, " erro"}, 32'(erro_multiplo), 32'(erro));
        checa({nome, " estado"}, 32'(db_estado), 32'(est));
    endtask

    int r0;

    initial begin
        tab[0]  = '{9'h010, 1'b1, 2,  9'h000, 1'b0, 3'd0};
        tab[1]  = '{9'h010, 1'b1, 1,  9'h000, 1'b0, 3'd1};
        tab[2]  = '{9'h010, 1'b1, 4,  9'h000, 1'b0, 3'd1};
        tab[3]  = '{9'h010, 1'b1, 1,  9'h010, 1'b0, 3'd2};
        tab[4]  = '{9'h010, 1'b1, 12, 9'h010, 1'b0, 3'd2};
        tab[5]  = '{9'h000, 1'b1, 7,  9'h010, 1'b0, 3'd4};
        tab[6]  = '{9'h000, 1'b1, 1,  9'h000, 1'b0, 3'd0};
        tab[7]  = '{9'h005, 1'b1, 7,  9'h000, 1'b0, 3'd1};
        tab[8]  = '{9'h005, 1'b1, 1,  9'h000, 1'b1, 3'd3};
        tab[9]  = '{9'h005, 1'b1, 1,  9'h000, 1'b0, 3'd3};
        tab[10] = '{9'h005, 1'b1, 10, 9'h000, 1'b0, 3'd3};
        tab[11] = '{9'h000, 1'b1, 6,  9'h000, 1'b0, 3'd3};
        tab[12] = '{9'h000, 1'b1, 1,  9'h000, 1'b0, 3'd0};
        tab[13] = '{9'h010, 1'b0, 10, 9'h000, 1'b0, 3'd0};
        tab[14] = '{9'h010, 1'b1, 5,  9'h000, 1'b0, 3'd1};
        tab[15] = '{9'h010, 1'b1, 1,  9'h010, 1'b0, 3'd2};
        tab[16] = '{9'h000, 1'b1, 8,  9'h000, 1'b0, 3'd0};

        reset      = 1'b0;
        botoes_raw = '0;
        enable     = 1'b1;
        #1;
        checa_saidas("reset", 9'h000, 1'b0, 3'd0);
        ciclo(2);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            botoes_raw = tab[i].raw;
            enable     = tab[i].en;
            ciclo(tab[i].ciclos);
            checa_saidas($sformatf("vec%0d", i), tab[i].exp_bot, tab[i].exp_erro,
                         tab[i].exp_est);
        end

        // Bit 0 with bounce: on 2, off 2, then steady on.
        r0 = rises;
        botoes_raw = 9'h001;
        ciclo(2);
        botoes_raw = 9'h000;
        ciclo(2);
        botoes_raw = 9'h001;
        ciclo(7);
        checa("bounce pre", 32'(botoes), 32'h000);
        ciclo(1);
        checa("bounce accept", 32'(botoes), 32'h001);
        ciclo(4);
        checa("bounce single rise", 32'(rises - r0), 32'd1);
        botoes_raw = 9'h000;
        ciclo(8);
        checa("bounce release", 32'(botoes), 32'h000);

        // Bit 8, extra bit 3 while held, release with a bounce.
        r0 = rises;
        botoes_raw = 9'h100;
        ciclo(8);
        checa("b8 accept", 32'(botoes), 32'h100);
        botoes_raw = 9'h108;
        ciclo(10);
        checa("b8 extra", 32'(botoes), 32'h100);
        checa("b8 extra est", 32'(db_estado), 32'd2);
        botoes_raw = 9'h000;
        ciclo(2);
        botoes_raw = 9'h100;
        ciclo(2);
        checa("b8 bounce", 32'(botoes), 32'h100);
        botoes_raw = 9'h000;
        ciclo(6);
        checa("b8 hold", 32'(botoes), 32'h100);
        checa("b8 hold est", 32'(db_estado), 32'd4);
        ciclo(1);
        checa("b8 drop", 32'(botoes), 32'h000);
        checa("b8 drop est", 32'(db_estado), 32'd0);
        checa("b8 single rise", 32'(rises - r0), 32'd1);

        // Reset while accepted, button still held.
        botoes_raw = 9'h010;
        ciclo(8);
        checa("rst pre", 32'(botoes), 32'h010);
        #2;
        reset = 1'b0;
        #1;
        checa("rst async bot", 32'(botoes), 32'h000);
        checa("rst async est", 32'(db_estado), 32'd0);
        ciclo(1);
        reset = 1'b1;
        ciclo(7);
        checa("rst redeb pre", 32'(botoes), 32'h000);
        ciclo(1);
        checa("rst redeb", 32'(botoes), 32'h010);
        botoes_raw = 9'h000;
        ciclo(8);
        checa("rst release", 32'(botoes), 32'h000);

        ciclo(2);
        checa("invariant", 32'(viol), 32'd0);
        checa("erro pulses", 32'(pulsos), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
